// File: rtl/video_pkg.sv
// Shared definitions for the video decimate/pack block.
// - mode_e : per-axis decimation ratio carried on mode_h / mode_v
// - keep() : decides whether a pixel or line survives decimation,
//            using the low two bits of its index within the line/frame
package video_pkg;

  typedef enum logic [1:0] {
    MODE_ALL     = 2'b00,  // keep every sample
    MODE_HALF    = 2'b01,  // keep 1 of 2
    MODE_QUARTER = 2'b10,  // keep 1 of 4
    MODE_THREEQ  = 2'b11   // keep 3 of 4 (drop index 3 of each group)
  } mode_e;

  function automatic logic keep(input mode_e mode, input logic [1:0] k);
    case (mode)
      MODE_ALL:     keep = 1'b1;
      MODE_HALF:    keep = ~k[0];
      MODE_QUARTER: keep = (k == 2'b00);
      MODE_THREEQ:  keep = (k != 2'b11);
      default:      keep = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/video_decimate_pack_if.sv
// Packed-word output bus of video_decimate_pack towards the DDR write arbiter.
// Ports (signals):
//   out_data  BUS_W  FIFO head word (show-ahead, valid while out_valid)
//   out_valid 1      a word is available
//   out_ready 1      consumer accepts the head word
//   burst_req 1      enough words buffered for a burst
//   trans_id  4      channel tag while a burst is requested, else 0
// Handshake: a word transfers on every clock edge where out_valid and
// out_ready are both high; out_data is stable while out_valid is high and
// no transfer has happened; out_ready may be high without out_valid (ignored).
interface video_decimate_pack_if #(
  parameter int BUS_W = 256
);
  logic [BUS_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             burst_req;
  logic [3:0]       trans_id;

  modport master (
    output out_data,
    output out_valid,
    output burst_req,
    output trans_id,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  burst_req,
    input  trans_id,
    output out_ready
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock show-ahead FIFO with occupancy output.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   push       write request; push_data stored unless the FIFO is full
//              and no pop happens in the same cycle
//   pop        read request; ignored when empty
//   head       current head word (0 when empty)
//   empty      no word stored
//   level      number of stored words, 0..DEPTH
//   drop       1 in a cycle where a push was discarded because of full
module sync_fifo_fwft #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/video_decimate_pack.sv
// Decimates an RGB565 video stream by a runtime H/V ratio, packs kept pixels
// into BUS_W words (first pixel in the LSBs) and buffers them in a FIFO that
// feeds the DDR write arbiter. One instance per camera channel.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   vs_in         vertical sync, rising edge starts a frame
//   de_in, pix_in data enable and pixel
//   mode_h/mode_v decimation ratio per axis, latched only at frame start
//   out_if        packed word bus (data/valid/ready, burst_req, trans_id)
//   frame_start   one-cycle pulse per vs_in rising edge
//   overflow      sticky, set when a word was dropped on a full FIFO
module video_decimate_pack
  import video_pkg::*;
#(
  parameter int         PIX_W        = 16,
  parameter int         BUS_W        = 256,
  parameter int         VIDEO_WIDTH  = 1280,
  parameter int         VIDEO_HEIGHT = 720,
  parameter int         FIFO_DEPTH   = 32,
  parameter int         BURST_LEN    = 8,
  parameter logic [3:0] IMAGE_TAG    = 4'd1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vs_in,
  input  logic                   de_in,
  input  logic [PIX_W-1:0]       pix_in,
  input  logic [1:0]             mode_h,
  input  logic [1:0]             mode_v,
  video_decimate_pack_if.master  out_if,
  output logic                   frame_start,
  output logic                   overflow
);
  localparam int N   = BUS_W / PIX_W;
  localparam int SW  = (N > 1) ? $clog2(N) : 1;
  localparam int PXW = ($clog2(VIDEO_WIDTH) > 2) ? $clog2(VIDEO_WIDTH) : 2;
  localparam int LNW = ($clog2(VIDEO_HEIGHT) > 2) ? $clog2(VIDEO_HEIGHT) : 2;
  localparam int LVW = $clog2(FIFO_DEPTH) + 1;

  // Input stage and edge detection
  logic             vs_d1, vs_d2;
  logic             de_d1, de_d2;
  logic [PIX_W-1:0] pix_d1;
  logic             vs_rise, de_rise, de_fall;

  // Position counters and frame-latched modes
  logic [PXW-1:0]   pix_idx;
  logic [PXW-1:0]   cur_pix_idx;
  logic [LNW-1:0]   line_idx;
  mode_e            mode_h_q, mode_v_q;
  logic             kept;

  // Packer
  logic [BUS_W-1:0] word_q, word_n;
  logic [SW-1:0]    slot_q, slot_n;
  logic             push;

  // FIFO / status
  logic [BUS_W-1:0] fifo_head;
  logic             fifo_empty;
  logic [LVW-1:0]   fifo_level;
  logic             fifo_drop;
  logic             burst;

  assign vs_rise = vs_d1 & ~vs_d2;
  assign de_rise = de_d1 & ~de_d2;
  assign de_fall = ~de_d1 & de_d2;

  // The first pixel of a line sees index 0 even though the register still
  // holds the previous line's count.
  assign cur_pix_idx = de_rise ? '0 : pix_idx;
  assign kept = de_d1 & keep(mode_v_q, line_idx[1:0]) & keep(mode_h_q, cur_pix_idx[1:0]);

  // Pack the current pixel first, then a frame edge flushes whatever is
  // partially filled. word_q is cleared after every push, so unused slots
  // of a flushed word are already zero.
  always_comb begin
    word_n = word_q;
    slot_n = slot_q;
    push   = 1'b0;
    if (kept) begin
      for (int j = 0; j < N; j++) begin
        if (slot_q == SW'(j)) word_n[j*PIX_W +: PIX_W] = pix_d1;
      end
      if (slot_q == SW'(N-1)) begin
        push   = 1'b1;
        slot_n = '0;
      end else begin
        slot_n = slot_q + 1'b1;
      end
    end
    if (vs_rise) begin
      if (slot_n != '0) push = 1'b1;
      slot_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d1       <= 1'b0;
      vs_d2       <= 1'b0;
      de_d1       <= 1'b0;
      de_d2       <= 1'b0;
      pix_d1      <= '0;
      pix_idx     <= '0;
      line_idx    <= '0;
      mode_h_q    <= MODE_ALL;
      mode_v_q    <= MODE_ALL;
      word_q      <= '0;
      slot_q      <= '0;
      frame_start <= 1'b0;
      overflow    <= 1'b0;
      out_if.trans_id <= 4'd0;
    end else begin
      vs_d1  <= vs_in;
      vs_d2  <= vs_d1;
      de_d1  <= de_in;
      de_d2  <= de_d1;
      pix_d1 <= pix_in;

      if (de_d1) pix_idx <= cur_pix_idx + 1'b1;

      if (vs_rise) begin
        line_idx <= '0;
        mode_h_q <= mode_e'(mode_h);
        mode_v_q <= mode_e'(mode_v);
      end else if (de_fall) begin
        line_idx <= line_idx + 1'b1;
      end

      word_q <= push ? '0 : word_n;
      slot_q <= slot_n;

      frame_start <= vs_rise;
      if (fifo_drop) overflow <= 1'b1;
      out_if.trans_id <= burst ? IMAGE_TAG : 4'd0;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (BUS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (word_n),
    .pop       (out_if.out_ready),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .drop      (fifo_drop)
  );

  assign burst            = (fifo_level >= LVW'(BURST_LEN));
  assign out_if.out_data  = fifo_head;
  assign out_if.out_valid = ~fifo_empty;
  assign out_if.burst_req = burst;

endmodule

// File: tb/tb_video_decimate_pack.sv
// Bench for video_decimate_pack: 16x8 frames, 4 pixels per 64-bit word,
// 8-word FIFO, burst threshold 2. A frame-level model builds the expected
// word stream; one compare process checks every popped word.
module tb_video_decimate_pack;
  localparam int PIX_W = 16;
  localparam int BUS_W = 64;
  localparam int N     = 4;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             vs_in = 1'b0;
  logic             de_in = 1'b0;
  logic [PIX_W-1:0] pix_in = '0;
  logic [1:0]       mode_h = 2'b00;
  logic [1:0]       mode_v = 2'b00;
  logic             frame_start;
  logic             overflow;

  video_decimate_pack_if #(.BUS_W(BUS_W)) out_if ();

  video_decimate_pack #(
    .PIX_W(PIX_W), .BUS_W(BUS_W), .VIDEO_WIDTH(16), .VIDEO_HEIGHT(8),
    .FIFO_DEPTH(DEPTH), .BURST_LEN(2), .IMAGE_TAG(4'd1)
  ) dut (
    .clk(clk), .rst(rst), .vs_in(vs_in), .de_in(de_in), .pix_in(pix_in),
    .mode_h(mode_h), .mode_v(mode_v), .out_if(out_if),
    .frame_start(frame_start), .overflow(overflow)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [BUS_W-1:0] exp_q[$];
  logic [BUS_W-1:0] got_q[$];
  logic [BUS_W-1:0] exp_w;
  int               fs_cnt = 0;
  bit               tid_valid = 1'b0;
  logic             prev_burst = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [PIX_W-1:0] m_part[$];
  int               m_line = 0;
  logic [1:0]       m_mh = 2'b00;
  logic [1:0]       m_mv = 2'b00;
  bit               m_cap = 1'b0;   // consumer stalled: FIFO holds at most DEPTH words

  function automatic bit m_keep(input logic [1:0] ratio, input int k);
    case (ratio)
      2'd0:    return 1'b1;
      2'd1:    return (k % 2) == 0;
      2'd2:    return (k % 4) == 0;
      default: return (k % 4) != 3;
    endcase
  endfunction

  function automatic void m_emit();
    logic [BUS_W-1:0] w;
    w = '0;
    for (int j = 0; j < m_part.size(); j++) w[j*PIX_W +: PIX_W] = m_part[j];
    m_part.delete();
    if (!(m_cap && exp_q.size() >= DEPTH)) exp_q.push_back(w);
  endfunction

  function automatic void m_pixel(input logic [PIX_W-1:0] px, input int idx);
    if (m_keep(m_mv, m_line) && m_keep(m_mh, idx)) begin
      m_part.push_back(px);
      if (m_part.size() == N) m_emit();
    end
  endfunction

  function automatic void m_vs();
    if (m_part.size() > 0) m_emit();
    m_mh   = mode_h;
    m_mv   = mode_v;
    m_line = 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    vs_in = 1'b1;
    m_vs();
    repeat (3) tick();
    vs_in = 1'b0;
    repeat (2) tick();
  endtask

  // One line of npix pixels valued base + line*16 + index. vs_last raises
  // vs_in together with the last pixel; ready_pulse opens out_ready for the
  // single cycle in which the last pixel's word is pushed.
  task automatic drive_line(input int base, input int npix, input bit vs_last, input bit ready_pulse);
    for (int p = 0; p < npix; p++) begin
      de_in  = 1'b1;
      pix_in = PIX_W'(base + m_line * 16 + p);
      if (vs_last && p == npix - 1) vs_in = 1'b1;
      m_pixel(pix_in, p);
      if (vs_last && p == npix - 1) m_vs();
      tick();
    end
    de_in  = 1'b0;
    pix_in = '0;
    if (ready_pulse) out_if.out_ready = 1'b1;
    tick();
    if (ready_pulse) out_if.out_ready = 1'b0;
    m_line++;
    if (vs_last) begin
      repeat (2) tick();
      vs_in = 1'b0;
    end
    repeat (2) tick();
  endtask

  task automatic frame(input int base, input int nlines, input int npix);
    vs_pulse();
    for (int l = 0; l < nlines; l++) drive_line(base, npix, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    de_in = 1'b0;
    vs_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid",   out_if.out_valid, 64'd0);
    check("rst_out_data",    out_if.out_data,  64'd0);
    check("rst_burst_req",   out_if.burst_req, 64'd0);
    check("rst_trans_id",    out_if.trans_id,  64'd0);
    check("rst_frame_start", frame_start,      64'd0);
    check("rst_overflow",    overflow,         64'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    m_part.delete();
    m_line = 0;
    m_mh   = 2'b00;
    m_mv   = 2'b00;
    m_cap  = 1'b0;
    fs_cnt = 0;
    tick();
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_if.out_valid && out_if.out_ready) begin
        got_q.push_back(out_if.out_data);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL word_pop: got 0x%0h, expected no word (t=%0t)", out_if.out_data, $time);
        end else begin
          exp_w = exp_q.pop_front();
          check("word_data", out_if.out_data, exp_w);
        end
      end
      if (tid_valid) check("trans_id_lag", out_if.trans_id, prev_burst ? 64'd1 : 64'd0);
      tid_valid  = !rst;
      prev_burst = out_if.burst_req;
      if (!rst && frame_start) fs_cnt++;
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    bit found;
    out_if.out_ready = 1'b0;
    do_reset();

    // 1: full resolution, consumer always ready
    mode_h = 2'b00; mode_v = 2'b00; out_if.out_ready = 1'b1;
    frame(0, 8, 16);
    vs_pulse();
    repeat (10) tick();
    check("t1_words",  got_q.size(), 64'd32);
    check("t1_word0",  got_q[0],  64'h0003_0002_0001_0000);
    check("t1_word31", got_q[31], 64'h007F_007E_007D_007C);
    check("t1_left",   exp_q.size(), 64'd0);

    // 2: quarter x quarter
    do_reset();
    mode_h = 2'b10; mode_v = 2'b10; out_if.out_ready = 1'b1;
    frame(0, 8, 16);
    vs_pulse();
    repeat (10) tick();
    check("t2_words", got_q.size(), 64'd2);
    check("t2_word0", got_q[0], 64'h000C_0008_0004_0000);
    check("t2_word1", got_q[1], 64'h004C_0048_0044_0040);

    // 3: 3/4 horizontal, 1/2 vertical, consumer stalled -> overflow
    do_reset();
    mode_h = 2'b11; mode_v = 2'b01; out_if.out_ready = 1'b0; m_cap = 1'b1;
    found = 1'b0;
    fork
      frame(32'h200, 8, 16);
      begin
        for (int i = 0; i < 600; i++) begin
          @(negedge clk);
          if (out_if.burst_req) begin
            found = 1'b1;
            break;
          end
        end
        if (found) begin
          check("t3_tid_at_burst", out_if.trans_id, 64'd0);
          @(negedge clk);
          check("t3_tid_after",    out_if.trans_id, 64'd1);
        end else begin
          n_checks++;
          n_fail++;
          $display("FAIL t3_burst_wait: got burst_req=0 for 600 cycles, expected 1");
        end
      end
    join
    vs_pulse();
    repeat (4) tick();
    check("t3_overflow",  overflow,         64'd1);
    check("t3_burst_req", out_if.burst_req, 64'd1);
    check("t3_trans_id",  out_if.trans_id,  64'd1);
    check("t3_valid",     out_if.out_valid, 64'd1);
    m_cap = 1'b0;
    out_if.out_ready = 1'b1;
    repeat (14) tick();
    check("t3_words", got_q.size(), 64'd8);
    check("t3_word0", got_q[0], 64'h0204_0202_0201_0200);
    check("t3_left",  exp_q.size(), 64'd0);

    // 4: flush of a partial word, then a kept pixel coincident with vs rise
    do_reset();
    mode_h = 2'b01; mode_v = 2'b10; out_if.out_ready = 1'b1;
    vs_pulse();
    drive_line(32'h100, 6, 1'b0, 1'b0);
    vs_pulse();
    drive_line(32'h300, 3, 1'b1, 1'b0);
    repeat (6) tick();
    check("t4_words", got_q.size(), 64'd2);
    check("t4_flush", got_q[0], 64'h0000_0104_0102_0100);
    check("t4_coinc", got_q[1], 64'h0000_0000_0302_0300);
    check("t4_frame_start_pulses", fs_cnt, 64'd3);

    // 5: mid-frame mode change is ignored until the next frame; rst mid-line
    do_reset();
    mode_h = 2'b00; mode_v = 2'b00; out_if.out_ready = 1'b1;
    vs_pulse();
    drive_line(32'h400, 16, 1'b0, 1'b0);
    mode_h = 2'b10;
    drive_line(32'h400, 16, 1'b0, 1'b0);
    out_if.out_ready = 1'b0;
    vs_pulse();
    repeat (4) tick();
    check("t5_words", got_q.size(), 64'd8);
    check("t5_word4", got_q[4], 64'h0413_0412_0411_0410);
    drive_line(32'h500, 16, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_new_mode_valid", out_if.out_valid, 64'd1);
    check("t5_new_mode_head",  out_if.out_data,  64'h050C_0508_0504_0500);
    tick();
    de_in = 1'b1; pix_in = 16'h0551; tick();
    pix_in = 16'h0552; tick();
    do_reset();
    mode_h = 2'b00; mode_v = 2'b00; out_if.out_ready = 1'b1;
    vs_pulse();
    drive_line(32'h600, 4, 1'b0, 1'b0);
    vs_pulse();
    repeat (6) tick();
    check("t5_after_rst_words", got_q.size(), 64'd1);
    check("t5_after_rst_word",  got_q[0], 64'h0603_0602_0601_0600);

    // 6: push into a full FIFO while the head is popped in the same cycle
    do_reset();
    mode_h = 2'b00; mode_v = 2'b00; out_if.out_ready = 1'b0;
    vs_pulse();
    drive_line(32'h700, 16, 1'b0, 1'b0);
    drive_line(32'h700, 16, 1'b0, 1'b0);
    drive_line(32'h700, 4, 1'b0, 1'b1);
    repeat (3) tick();
    check("t6_overflow",  overflow,         64'd0);
    check("t6_burst_req", out_if.burst_req, 64'd1);
    check("t6_popped",    got_q.size(),     64'd1);
    out_if.out_ready = 1'b1;
    repeat (14) tick();
    check("t6_words", got_q.size(), 64'd9);
    check("t6_word8", got_q[8], 64'h0723_0722_0721_0720);
    check("t6_left",  exp_q.size(), 64'd0);
    check("t6_overflow_end", overflow, 64'd0);

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
